pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Central pipeline sequencing controller for the 5-stage core (IF, ID, EX, MEM, WB).
- Takes stall requests from the stages, branch redirects from EX and exceptions/ertn from MEM.
- Drives per-stage stall enables and per-register flush strobes into the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Owns the PC redirect handshake to the fetch unit and keeps a stall-cycle performance counter.

Parameters:
- ADDR_W, 32, width of PC and redirect target.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- stallreq_if  input  1  IF needs more cycles (icache miss).
- stallreq_id  input  1  ID load-use hazard.
- stallreq_ex  input  1  EX multi-cycle op busy (mul/div).
- stallreq_mem  input  1  MEM needs more cycles (dcache miss).
- br_valid  input  1  EX resolved a taken or mispredicted branch.
- br_target  input  ADDR_W  branch target.
- exc_type  input  2  from MEM: 00 none, 01 syscall, 10 break, 11 ertn.
- exc_pc  input  ADDR_W  PC of the excepting instruction.
- csr_eentry  input  ADDR_W  exception entry address.
- csr_era  input  ADDR_W  ertn return address.
- pc_ready  input  1  fetch accepted the redirect this cycle.
- stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
- flush_if_id  output  1  clear IF/ID register.
- flush_id_ex  output  1  clear ID/EX register.
- flush_ex_mem  output  1  clear EX/MEM register.
- flush_mem_wb  output  1  clear MEM/WB register.
- redirect_valid  output  1  new PC offered to fetch.
- redirect_pc  output  ADDR_W  new PC.
- exc_commit  output  1  one-cycle pulse, exception or ertn accepted (CSR update strobe).
- stall_cycles  output  CNT_W  saturating count of cycles with stall[0]=1.

Behaviour:
- States: RUN, EXC_FLUSH, REDIRECT. All outputs are registered.
- Reset: state=RUN. stall=0, all flushes=0, redirect_valid=0, redirect_pc=0, exc_commit=0, stall_cycles=0. Reset mid-redirect abandons the redirect immediately.
- RUN, priority order exception > branch > stall:
  - exc_type!=00: next cycle all four flushes=1, exc_commit=1, stall=0. Go to EXC_FLUSH. Latch redirect_pc = csr_era when exc_type=11, else csr_eentry.
  - Else br_valid: next cycle flush_if_id=1, flush_id_ex=1, redirect_valid=1, redirect_pc=br_target. Go to REDIRECT.
  - Else stall: highest requesting stage k (IF=1, ID=2, EX=3, MEM=4) sets stall[k:0]=1 and pulses the flush of the register following stage k (id_ex for ID, ex_mem for EX, mem_wb for MEM; none for IF), inserting a bubble. Multiple requests resolve to the highest stage. Latency is 1 cycle from request to stall.
- EXC_FLUSH: lasts exactly 1 cycle. Flushes drop to 0 and exc_commit drops. Assert redirect_valid, go to REDIRECT.
- REDIRECT:
  - stall[0]=1 (PC held) and redirect_valid=1 until pc_ready.
  - On pc_ready: redirect_valid=0 next cycle, return to RUN.
  - redirect_pc is stable while valid.
  - A new exception in REDIRECT preempts: re-latch the target, reflush, re-enter EXC_FLUSH.
  - br_valid in REDIRECT is ignored (wrong-path).
- Flush strobes are 1-cycle pulses, except a stall bubble, which repeats each cycle the request persists.
- stall_cycles increments when stall[0]=1 and saturates at all-ones (no wrap).

Test Plan:
- Reset, then idle with no requests -> stall=000000, all flushes=0, redirect_valid=0, stall_cycles=0.
- stallreq_ex=1 for 3 cycles -> stall=001111 and flush_ex_mem=1 for 3 cycles, then stall=0; stall_cycles=3.
- br_valid=1, br_target=0x1C000040, pc_ready low 2 cycles -> flush_if_id=flush_id_ex=1 for 1 cycle; redirect_valid held 3 cycles with redirect_pc=0x1C000040; cleared after the pc_ready cycle.
- exc_type=01 with br_valid=1 and stallreq_mem=1 simultaneously, csr_eentry=0x1C008000 -> all flushes=1 and exc_commit=1 for 1 cycle; redirect_pc=0x1C008000; the branch is ignored.
- exc_type=11, csr_era=0x1C000100 -> redirect_pc=0x1C000100 after EXC_FLUSH.
- Force stall_cycles near saturation with CNT_W=4 and stall 20 cycles -> counter holds at 15; rst asserted during REDIRECT -> redirect_valid=0 on the next edge.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: stall/flush generation,
// PC redirect handshake toward fetch and a saturating stall-cycle counter.
module pipe_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [1:0]        exc_type,
    input  logic [ADDR_W-1:0] exc_pc,
    input  logic [ADDR_W-1:0] csr_eentry,
    input  logic [ADDR_W-1:0] csr_era,
    input  logic              pc_ready,
    output logic [5:0]        stall,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              flush_ex_mem,
    output logic              flush_mem_wb,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              exc_commit,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StExcFlush = 2'd1,
        StRedirect = 2'd2
    } state_e;

    localparam logic [1:0] ExcNone = 2'b00;
    localparam logic [1:0] ExcErtn = 2'b11;

    state_e              state_q, state_d;
    logic [5:0]          stall_q, stall_d;
    // Flush bits: [0] IF/ID, [1] ID/EX, [2] EX/MEM, [3] MEM/WB.
    logic [3:0]          flush_q, flush_d;
    logic                redirect_valid_q, redirect_valid_d;
    logic [ADDR_W-1:0]   redirect_pc_q, redirect_pc_d;
    logic                exc_commit_q, exc_commit_d;
    logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;

    logic                exc_taken;
    logic [ADDR_W-1:0]   exc_target;

    // The faulting PC is recorded into ERA by the CSR unit, not here.
    logic unused_exc_pc;
    assign unused_exc_pc = ^exc_pc;

    assign exc_taken  = (exc_type != ExcNone);
    assign exc_target = (exc_type == ExcErtn) ? csr_era : csr_eentry;

    always_comb begin
        state_d          = state_q;
        stall_d          = 6'b000000;
        flush_d          = 4'b0000;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        exc_commit_d     = 1'b0;

        unique case (state_q)
            StRun: begin
                if (exc_taken) begin
                    flush_d       = 4'b1111;
                    exc_commit_d  = 1'b1;
                    redirect_pc_d = exc_target;
                    state_d       = StExcFlush;
                end else if (br_valid) begin
                    flush_d          = 4'b0011;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = br_target;
                    stall_d          = 6'b000001;
                    state_d          = StRedirect;
                end else if (stallreq_mem) begin
                    stall_d    = 6'b011111;
                    flush_d[3] = 1'b1;
                end else if (stallreq_ex) begin
                    stall_d    = 6'b001111;
                    flush_d[2] = 1'b1;
                end else if (stallreq_id) begin
                    stall_d    = 6'b000111;
                    flush_d[1] = 1'b1;
                end else if (stallreq_if) begin
                    stall_d    = 6'b000011;
                end
            end

            StExcFlush: begin
                redirect_valid_d = 1'b1;
                stall_d          = 6'b000001;
                state_d          = StRedirect;
            end

            StRedirect: begin
                // Branches here are wrong-path; only a new exception can preempt.
                if (exc_taken) begin
                    flush_d       = 4'b1111;
                    exc_commit_d  = 1'b1;
                    redirect_pc_d = exc_target;
                    state_d       = StExcFlush;
                end else if (pc_ready) begin
                    state_d = StRun;
                end else begin
                    redirect_valid_d = 1'b1;
                    stall_d          = 6'b000001;
                end
            end

            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_q[0] && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StRun;
            stall_q          <= 6'b000000;
            flush_q          <= 4'b0000;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            exc_commit_q     <= 1'b0;
            stall_cycles_q   <= '0;
        end else begin
            state_q          <= state_d;
            stall_q          <= stall_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            exc_commit_q     <= exc_commit_d;
            stall_cycles_q   <= stall_cycles_d;
        end
    end

    assign stall          = stall_q;
    assign flush_if_id    = flush_q[0];
    assign flush_id_ex    = flush_q[1];
    assign flush_ex_mem   = flush_q[2];
    assign flush_mem_wb   = flush_q[3];
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign exc_commit     = exc_commit_q;
    assign stall_cycles   = stall_cycles_q;

endmodule
